// File: rtl/string_match_pkg.sv
// Shared types and helpers for the parallel-NFA match reporting path.
// Event records carry the pattern id and the byte position that completed the match.
package string_match_pkg;

    localparam int WEIGHT_NUM = 20;
    localparam int ID_W       = 5;
    localparam int POS_W      = 16;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [POS_W-1:0] pos;
    } match_event_t;

    // Index of the lowest set bit; zero when the vector is empty.
    function automatic logic [ID_W-1:0] lowest_set(input logic [WEIGHT_NUM-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = WEIGHT_NUM - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/match_event_fifo.sv
// Synchronous FIFO of match events with full/empty flags.
// The head entry is read straight from the storage registers, so it is stable while not popped.
module match_event_fifo
    import string_match_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  match_event_t wr_ev,
    input  logic         pop,
    output match_event_t head,
    output logic         full,
    output logic         empty
);

    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);
    localparam logic [AW:0]    CNT_ONE = (AW + 1)'(1);

    match_event_t  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    // A push is refused while full even if a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_ev;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/match_event_reporter.sv
// Serialises per-character match bitmaps into {id, pos} events and drains them over valid/ready.
// Upstream is held off whenever a multi-hit bitmap is still being unpacked.
module match_event_reporter
    import string_match_pkg::match_event_t;
    import string_match_pkg::lowest_set;
#(
    parameter int WEIGHT_NUM = string_match_pkg::WEIGHT_NUM,
    parameter int ID_W       = string_match_pkg::ID_W,
    parameter int POS_W      = string_match_pkg::POS_W,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sof,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WEIGHT_NUM-1:0] match_vec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ID_W-1:0]       out_id,
    output logic [POS_W-1:0]      out_pos,
    output logic [CNT_W-1:0]      match_cnt,
    output logic                  busy
);

    localparam logic [WEIGHT_NUM-1:0] VEC_ONE = WEIGHT_NUM'(1);
    localparam logic [POS_W-1:0]      POS_ONE = POS_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_MAX = '1;

    logic [POS_W-1:0]      pos;
    logic [POS_W-1:0]      cur_pos;
    logic [POS_W-1:0]      pend_pos;
    logic [WEIGHT_NUM-1:0] pend_vec;
    logic [CNT_W-1:0]      cnt;
    logic                  pend_any;
    logic                  pend_onehot;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  acc;
    logic                  push;
    match_event_t          push_ev;
    match_event_t          head;

    assign pend_any    = |pend_vec;
    assign pend_onehot = pend_any && ((pend_vec & (pend_vec - VEC_ONE)) == '0);
    // A new bitmap may only land when the pending one empties during this same cycle.
    assign in_ready    = !pend_any || (pend_onehot && !fifo_full);
    assign acc         = in_valid && in_ready;
    assign cur_pos     = sof ? '0 : pos;
    assign push        = pend_any && !fifo_full;

    always_comb begin
        push_ev                = '0;
        push_ev.id             = lowest_set(pend_vec);
        push_ev.pos[POS_W-1:0] = pend_pos;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos      <= '0;
            pend_vec <= '0;
            pend_pos <= '0;
            cnt      <= '0;
        end else begin
            if (acc) begin
                pos <= cur_pos + POS_ONE;
            end
            // Accept only happens with at most the last bit pending, so the reload never drops an event.
            if (acc) begin
                pend_vec <= match_vec;
            end else if (push) begin
                pend_vec <= pend_vec & (pend_vec - VEC_ONE);
            end
            if (acc && (|match_vec)) begin
                pend_pos <= cur_pos;
            end
            if (push && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    match_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wr_ev (push_ev),
        .pop   (out_ready),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_id    = head.id;
    assign out_pos   = head.pos[POS_W-1:0];
    assign match_cnt = cnt;
    assign busy      = pend_any || !fifo_empty;

endmodule

// File: tb/tb_match_event_reporter.sv
// Directed bench for match_event_reporter: a cycle table plus hand sequences for fill, wrap and reset.
module tb_match_event_reporter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sof, in_valid, out_ready;
    logic [19:0] match_vec;
    logic        in_ready, out_valid, busy;
    logic [4:0]  out_id;
    logic [15:0] out_pos, match_cnt;

    logic        sof4, in_valid4, out_ready4;
    logic [19:0] match_vec4;
    logic        in_ready4, out_valid4, busy4;
    logic [4:0]  out_id4;
    logic [3:0]  out_pos4;
    logic [2:0]  match_cnt4;

    match_event_reporter dut (
        .clk(clk), .reset(reset), .sof(sof), .in_valid(in_valid), .in_ready(in_ready),
        .match_vec(match_vec), .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_pos(out_pos), .match_cnt(match_cnt), .busy(busy)
    );

    match_event_reporter #(.POS_W(4), .CNT_W(3)) dut4 (
        .clk(clk), .reset(reset), .sof(sof4), .in_valid(in_valid4), .in_ready(in_ready4),
        .match_vec(match_vec4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_id(out_id4), .out_pos(out_pos4), .match_cnt(match_cnt4), .busy(busy4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sof;
        logic        iv;
        logic [19:0] mv;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [4:0]  e_id;
        logic [15:0] e_pos;
        logic        e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic iv, input logic [19:0] mv, input logic ordy,
                                input logic ir, input logic ov, input logic [4:0] id,
                                input logic [15:0] p, input logic b, input logic [15:0] c);
        vec_t v;
        v.sof = s; v.iv = iv; v.mv = mv; v.ordy = ordy;
        v.e_ir = ir; v.e_ov = ov; v.e_id = id; v.e_pos = p; v.e_busy = b; v.e_cnt = c;
        return v;
    endfunction

    vec_t tbl [19];
    int   exp_pos4 [26] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1,
                            0, 1, 2, 3, 4, 5, 0, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  got;
        int  c4;
        logic acc_now;

        // outputs are sampled before the edge; each row's expectations describe state from earlier rows
        tbl[0]  = mk(1, 1, 20'h00000, 1,  1, 0,  0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 20'h00000, 1,  1, 0,  0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 20'h00000, 1,  1, 0,  0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 20'h00001, 1,  1, 0,  0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 20'h00000, 1,  1, 0,  0, 0, 1, 0);
        tbl[5]  = mk(0, 0, 20'h00000, 1,  1, 1,  0, 3, 1, 1);
        tbl[6]  = mk(0, 0, 20'h00000, 1,  1, 0,  0, 0, 0, 1);
        tbl[7]  = mk(1, 1, 20'h80005, 1,  1, 0,  0, 0, 0, 1);
        tbl[8]  = mk(0, 0, 20'h00000, 1,  0, 0,  0, 0, 1, 1);
        tbl[9]  = mk(0, 0, 20'h00000, 1,  0, 1,  0, 0, 1, 2);
        tbl[10] = mk(0, 0, 20'h00000, 1,  1, 1,  2, 0, 1, 3);
        tbl[11] = mk(0, 0, 20'h00000, 1,  1, 1, 19, 0, 1, 4);
        tbl[12] = mk(0, 0, 20'h00000, 1,  1, 0,  0, 0, 0, 4);
        tbl[13] = mk(0, 1, 20'h00020, 1,  1, 0,  0, 0, 0, 4);
        tbl[14] = mk(0, 1, 20'h00003, 1,  1, 0,  0, 0, 1, 4);
        tbl[15] = mk(0, 0, 20'h00000, 1,  0, 1,  5, 1, 1, 5);
        tbl[16] = mk(0, 0, 20'h00000, 1,  1, 1,  0, 2, 1, 6);
        tbl[17] = mk(0, 0, 20'h00000, 1,  1, 1,  1, 2, 1, 7);
        tbl[18] = mk(0, 0, 20'h00000, 1,  1, 0,  0, 0, 0, 7);

        reset = 1'b0;
        sof = 0; in_valid = 0; match_vec = '0; out_ready = 0;
        sof4 = 0; in_valid4 = 0; match_vec4 = '0; out_ready4 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_id", out_id, 0);
        check("rst_out_pos", out_pos, 0);
        check("rst_match_cnt", match_cnt, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // single hit, multi-hit and back-to-back reload
        for (int i = 0; i < 19; i++) begin
            sof = tbl[i].sof; in_valid = tbl[i].iv; match_vec = tbl[i].mv; out_ready = tbl[i].ordy;
            #1;
            check($sformatf("row%0d_in_ready", i), in_ready, tbl[i].e_ir);
            check($sformatf("row%0d_out_valid", i), out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) begin
                check($sformatf("row%0d_out_id", i), out_id, tbl[i].e_id);
                check($sformatf("row%0d_out_pos", i), out_pos, tbl[i].e_pos);
            end
            check($sformatf("row%0d_busy", i), busy, tbl[i].e_busy);
            check($sformatf("row%0d_match_cnt", i), match_cnt, tbl[i].e_cnt);
            @(posedge clk);
            #1;
        end

        // fill the FIFO with out_ready low: ids 1..9 at positions 0..8
        sof = 0; in_valid = 0; match_vec = '0; out_ready = 0;
        for (int c = 0; c < 9; c++) begin
            sof = (c == 0); in_valid = 1; match_vec = 20'd1 << (c + 1);
            #1;
            check($sformatf("fill%0d_in_ready", c), in_ready, 1);
            @(posedge clk);
            #1;
        end
        sof = 0; in_valid = 0; match_vec = '0;
        #1;
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        check("full_out_id", out_id, 1);
        check("full_out_pos", out_pos, 0);
        check("full_busy", busy, 1);
        check("full_match_cnt", match_cnt, 15);
        @(posedge clk);
        #1;
        check("full_hold_id", out_id, 1);
        check("full_hold_pos", out_pos, 0);
        check("full_hold_in_ready", in_ready, 0);

        in_valid = 1; match_vec = 20'd1 << 10; out_ready = 1;
        got = 0;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            #1;
            if (out_valid) begin
                check($sformatf("drain%0d_id", got), out_id, got + 1);
                check($sformatf("drain%0d_pos", got), out_pos, got);
                got++;
            end
            acc_now = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc_now) begin
                in_valid = 0; match_vec = '0;
            end
        end
        check("drain_count", got, 10);
        check("drain_in_valid_taken", in_valid, 0);
        check("drain_out_valid", out_valid, 0);
        check("drain_busy", busy, 0);
        check("drain_match_cnt", match_cnt, 17);

        // narrow position counter wraps at 16; sof restarts the count; small counter saturates
        out_ready4 = 1;
        c4 = 0;
        got = 0;
        for (int cyc = 0; cyc < 100 && got < 26; cyc++) begin
            if (c4 < 26) begin
                in_valid4 = 1;
                sof4 = (c4 == 0) || (c4 == 18) || (c4 == 24);
                match_vec4 = 20'd1 << (c4 % 20);
            end else begin
                in_valid4 = 0; sof4 = 0; match_vec4 = '0;
            end
            #1;
            if (out_valid4) begin
                check($sformatf("wrap%0d_id", got), out_id4, got % 20);
                check($sformatf("wrap%0d_pos", got), out_pos4, exp_pos4[got]);
                got++;
            end
            acc_now = in_valid4 && in_ready4;
            @(posedge clk);
            #1;
            if (acc_now) c4++;
        end
        in_valid4 = 0; sof4 = 0; match_vec4 = '0;
        check("wrap_count", got, 26);
        check("wrap_cnt_saturated", match_cnt4, 7);

        // reset with three buffered events and two bits pending
        out_ready = 0;
        for (int c = 0; c < 4; c++) begin
            sof = 0; in_valid = 1;
            match_vec = (c < 3) ? (20'd1 << (c + 3)) : 20'h00030;
            @(posedge clk);
            #1;
        end
        in_valid = 0; match_vec = '0;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_in_ready", in_ready, 0);
        check("pre_rst_out_valid", out_valid, 1);
        check("pre_rst_match_cnt", match_cnt, 20);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_match_cnt", match_cnt, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_id", out_id, 0);
        check("midrst_out_pos", out_pos, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sof = 0; in_valid = 1; match_vec = 20'h00004; out_ready = 1;
        @(posedge clk);
        #1;
        in_valid = 0; match_vec = '0;
        got = 0;
        for (int cyc = 0; cyc < 10 && got == 0; cyc++) begin
            if (out_valid) begin
                check("post_rst_id", out_id, 2);
                check("post_rst_pos", out_pos, 0);
                got = 1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("post_rst_event_seen", got, 1);
        @(posedge clk);
        #1;
        check("post_rst_match_cnt", match_cnt, 1);
        check("post_rst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/match_event_reporter.md
Name: match_event_reporter

Overview:
- Downstream stage of the parallel-NFA System.
- Consumes the per-character match bitmap (`result`, one bit per weight/pattern) alongside a character-accepted strobe.
- Serialises every set bit into a discrete event {pattern id, byte position} and buffers events in a FIFO.
- Drains events over a valid/ready interface to the host/report logic.
- Applies backpressure upstream when it cannot absorb a multi-hit bitmap.

Parameters:
- WEIGHT_NUM, 20, width of match bitmap (number of patterns/weights).
- ID_W, 5, pattern id width, = $clog2(WEIGHT_NUM).
- POS_W, 16, byte-position counter width; wraps modulo 2^POS_W.
- FIFO_DEPTH, 8, event FIFO entries; power of two.
- CNT_W, 16, total-match counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- sof  input  1  start of new input string; restarts position at 0 (qualified by in_valid && in_ready).
- in_valid  input  1  one character consumed by NFA this cycle; match_vec valid.
- in_ready  output  1  reporter can accept this cycle.
- match_vec  input  WEIGHT_NUM  match bitmap for the character (System `result`).
- out_valid  output  1  event available.
- out_ready  input  1  consumer takes event.
- out_id  output  ID_W  matched pattern index.
- out_pos  output  POS_W  byte position of the character completing the match.
- match_cnt  output  CNT_W  saturating count of events pushed into FIFO since reset.
- busy  output  1  pend_vec != 0 or FIFO non-empty.

Behaviour:
- Reset (reset=0, async):
  - pos counter = 0, pend_vec = 0, pend_pos = 0.
  - FIFO empty, match_cnt = 0.
  - out_valid = 0, in_ready = 1, busy = 0, out_id = 0, out_pos = 0.
- Reset mid-operation drops all pending and buffered events; no partial output.
- Accept: acc = in_valid && in_ready.
  - in_ready = (pend_vec == 0) || (pend_vec is one-hot && !fifo_full).
  - in_ready is combinational from registers only; no path from in_valid.
- Position:
  - On acc: cur_pos = sof ? 0 : pos; pos <= cur_pos + 1 (wraps).
  - If match_vec != 0 on acc: pend_pos <= cur_pos.
  - On wrap, 2^POS_W-1 is followed by 0.
- Serialiser: each cycle, if pend_vec != 0 and !fifo_full:
  - Push {idx, pend_pos}, where idx is the lowest set bit of pend_vec.
  - Clear that bit.
  - If acc also occurs this cycle (only possible when pend_vec is one-hot), pend_vec <= match_vec and pend_pos updates. The new bitmap replaces the cleared last bit; no event is lost.
- match_vec == 0 on acc: pend_vec unchanged (0), only pos advances.
- Ordering: events in ascending character position; within one position, ascending pattern id.
- Latency:
  - Bitmap accepted at edge E0, loaded into pend.
  - First event written at E1; out_valid high after E1.
  - k set bits need k cycles, absent FIFO-full stalls.
- FIFO (registered outputs):
  - push only when !full; pop on out_valid && out_ready.
  - Push and pop in the same cycle allowed when not full and not empty; occupancy unchanged.
  - No push when full even if a pop occurs that cycle; the push waits a cycle.
  - out_id/out_pos hold stable while out_valid && !out_ready.
- match_cnt increments per push; saturates at 2^CNT_W-1.
- Bits in match_vec at index >= WEIGHT_NUM do not exist; ids are always < WEIGHT_NUM.

Decomposition:
- Shared package string_match_pkg:
  - WEIGHT_NUM, ID_W, POS_W constants.
  - typedef match_event_t {id, pos}.
  - Lowest-set-bit function.
- Sub-module match_event_fifo:
  - Synchronous FIFO of match_event_t, FIFO_DEPTH, full/empty flags, async active-low reset.
- Top contains the pos counter, pend registers, serialiser and counter.

Test Plan:
- Reset then 5 chars, match_vec=0 except char 3 = 20'h00001 → one event id=0, pos=3; match_cnt=1.
- char 0 with match_vec=20'h80005 (bits 0,2,19) → events (0,0),(2,0),(19,0) on consecutive cycles with out_ready=1; in_ready low for 2 cycles after acceptance, high on the third.
- out_ready=0, feed 10 single-bit matches → FIFO fills at 8; in_ready drops with pend one-hot and full; release out_ready → all 10 events emerge in position order, none lost/duplicated.
- POS_W=4 override, 18 chars with a match on every char → positions 0..15, 0, 1; sof on char 6 of a second string → pos restarts 0.
- Pull reset low while 3 events are buffered and pend_vec=20'h00030 → out_valid=0, busy=0, match_cnt=0 immediately; next accepted match reports pos=0.
- Back-to-back: char n has a one-hot match, char n+1 has 20'h00003, FIFO not full → acc accepted same cycle the last bit is pushed; events (k,n),(0,n+1),(1,n+1) in order.
